// File: rtl/lag_scan_scheduler.sv
// Lag / sampling-divisor scan sequencer: on each packet-done step, walks all
// auto and cross scan entries through one shared adder/comparator, one per clock.
module lag_scan_scheduler #(
  parameter int NUM_INPUTS = 8,
  parameter int VAL_WIDTH  = 20,
  parameter int INC_WIDTH  = 12,
  parameter int DROP_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             step,
  input  logic                             load,
  input  logic                             hold,
  input  logic [NUM_INPUTS-1:0]            auto_en,
  input  logic [NUM_INPUTS-1:0]            cross_en,
  input  logic [NUM_INPUTS*VAL_WIDTH-1:0]  auto_start_a,
  input  logic [NUM_INPUTS*VAL_WIDTH-1:0]  auto_len_a,
  input  logic [NUM_INPUTS*INC_WIDTH-1:0]  auto_inc_a,
  input  logic [NUM_INPUTS*VAL_WIDTH-1:0]  cross_start_a,
  input  logic [NUM_INPUTS*VAL_WIDTH-1:0]  cross_len_a,
  input  logic [NUM_INPUTS*INC_WIDTH-1:0]  cross_inc_a,
  output logic [NUM_INPUTS*VAL_WIDTH-1:0]  auto_cur_a,
  output logic [NUM_INPUTS*VAL_WIDTH-1:0]  cross_cur_a,
  output logic [2*NUM_INPUTS-1:0]          wrap,
  output logic                             busy,
  output logic                             done,
  output logic [DROP_WIDTH-1:0]            drop_count,
  output logic [1:0]                       dbg_state,
  output logic                             dbg_pending
);

  // Handshake: step and load are single-cycle strobes with no ready; a step that
  // cannot be absorbed by the one-deep pending flag is counted in drop_count.

  localparam int NE = 2 * NUM_INPUTS;
  localparam int KW = (NE > 1) ? $clog2(NE) : 1;
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q;
  logic                   pending_q;
  logic                   sweep_start;
  logic [NE-1:0]          shadow_q;
  logic [VAL_WIDTH-1:0]   auto_cur  [NUM_INPUTS];
  logic [VAL_WIDTH-1:0]   cross_cur [NUM_INPUTS];

  // Shared datapath for the entry selected by k_q
  logic                   is_cross;
  logic [IW-1:0]          sel;
  logic                   en_sel;
  logic [VAL_WIDTH-1:0]   cur_sel;
  logic [VAL_WIDTH-1:0]   start_sel;
  logic [VAL_WIDTH-1:0]   len_sel;
  logic [INC_WIDTH-1:0]   inc_sel;
  logic [VAL_WIDTH:0]     next_sum;
  logic [VAL_WIDTH:0]     limit;
  logic                   advance;
  logic [VAL_WIDTH-1:0]   new_val;
  logic                   new_wrap;

  always_comb begin
    is_cross  = (k_q >= KW'(NUM_INPUTS));
    sel       = is_cross ? IW'(k_q - KW'(NUM_INPUTS)) : IW'(k_q);
    en_sel    = is_cross ? cross_en[sel] : auto_en[sel];
    cur_sel   = is_cross ? cross_cur[sel] : auto_cur[sel];
    start_sel = is_cross ? cross_start_a[sel*VAL_WIDTH +: VAL_WIDTH]
                         : auto_start_a[sel*VAL_WIDTH +: VAL_WIDTH];
    len_sel   = is_cross ? cross_len_a[sel*VAL_WIDTH +: VAL_WIDTH]
                         : auto_len_a[sel*VAL_WIDTH +: VAL_WIDTH];
    inc_sel   = is_cross ? cross_inc_a[sel*INC_WIDTH +: INC_WIDTH]
                         : auto_inc_a[sel*INC_WIDTH +: INC_WIDTH];
    // One extra bit so start+len and cur+inc never overflow before the compare
    next_sum  = {1'b0, cur_sel} + (VAL_WIDTH+1)'(inc_sel);
    limit     = {1'b0, start_sel} + {1'b0, len_sel};
    advance   = en_sel && (next_sum < limit);
    new_val   = advance ? next_sum[VAL_WIDTH-1:0] : start_sel;
    new_wrap  = en_sel && !advance;
  end

  always_comb begin
    state_d     = state_q;
    sweep_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((pending_q || step) && !hold) begin
          state_d     = S_SWEEP;
          sweep_start = 1'b1;
        end
      end
      S_SWEEP: begin
        if (k_q == KW'(NE - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (pending_q && !hold) begin
          state_d     = S_SWEEP;
          sweep_start = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d     = S_IDLE;
      sweep_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      wrap       <= '0;
      drop_count <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        auto_cur[i]  <= '0;
        cross_cur[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (load) begin
        // Abort any sweep; a step in the same cycle is discarded, not dropped
        k_q       <= '0;
        pending_q <= 1'b0;
        shadow_q  <= '0;
        wrap      <= '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          auto_cur[i]  <= auto_start_a[i*VAL_WIDTH +: VAL_WIDTH];
          cross_cur[i] <= cross_start_a[i*VAL_WIDTH +: VAL_WIDTH];
        end
      end else begin
        if (sweep_start) begin
          pending_q <= 1'b0;
          k_q       <= '0;
        end else if (step) begin
          pending_q <= 1'b1;
        end
        if (step && pending_q && (drop_count != {DROP_WIDTH{1'b1}})) begin
          drop_count <= drop_count + DROP_WIDTH'(1);
        end
        if (state_q == S_SWEEP) begin
          if (is_cross) cross_cur[sel] <= new_val;
          else          auto_cur[sel]  <= new_val;
          shadow_q[k_q] <= new_wrap;
          k_q           <= k_q + KW'(1);
        end
        if (state_q == S_DONE) wrap <= shadow_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_pack
    assign auto_cur_a[g*VAL_WIDTH +: VAL_WIDTH]  = auto_cur[g];
    assign cross_cur_a[g*VAL_WIDTH +: VAL_WIDTH] = cross_cur[g];
  end

  assign busy        = (state_q == S_SWEEP);
  assign done        = (state_q == S_DONE);
  assign dbg_state   = state_q;
  assign dbg_pending = pending_q;

endmodule

// File: tb/tb_lag_scan_scheduler.sv
// Directed bench for lag_scan_scheduler with two inputs (four scan entries)
// and a 2-bit drop counter so saturation is reachable.
module tb_lag_scan_scheduler;

  localparam int N  = 2;
  localparam int VW = 20;
  localparam int IW = 12;
  localparam int DW = 2;

  logic              clk;
  logic              reset;
  logic              step;
  logic              load;
  logic              hold;
  logic [N-1:0]      auto_en;
  logic [N-1:0]      cross_en;
  logic [N*VW-1:0]   auto_start_a;
  logic [N*VW-1:0]   auto_len_a;
  logic [N*IW-1:0]   auto_inc_a;
  logic [N*VW-1:0]   cross_start_a;
  logic [N*VW-1:0]   cross_len_a;
  logic [N*IW-1:0]   cross_inc_a;
  logic [N*VW-1:0]   auto_cur_a;
  logic [N*VW-1:0]   cross_cur_a;
  logic [2*N-1:0]    wrap;
  logic              busy;
  logic              done;
  logic [DW-1:0]     drop_count;
  logic [1:0]        dbg_state;
  logic              dbg_pending;

  int n_checks = 0;
  int n_pass   = 0;

  lag_scan_scheduler #(
    .NUM_INPUTS(N), .VAL_WIDTH(VW), .INC_WIDTH(IW), .DROP_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .load(load), .hold(hold),
    .auto_en(auto_en), .cross_en(cross_en),
    .auto_start_a(auto_start_a), .auto_len_a(auto_len_a), .auto_inc_a(auto_inc_a),
    .cross_start_a(cross_start_a), .cross_len_a(cross_len_a), .cross_inc_a(cross_inc_a),
    .auto_cur_a(auto_cur_a), .cross_cur_a(cross_cur_a), .wrap(wrap),
    .busy(busy), .done(done), .drop_count(drop_count),
    .dbg_state(dbg_state), .dbg_pending(dbg_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic set_auto(input int i, input logic en, input logic [VW-1:0] s,
                          input logic [VW-1:0] l, input logic [IW-1:0] inc);
    auto_en[i] = en;
    auto_start_a[i*VW +: VW] = s;
    auto_len_a[i*VW +: VW]   = l;
    auto_inc_a[i*IW +: IW]   = inc;
  endtask

  task automatic set_cross(input int i, input logic en, input logic [VW-1:0] s,
                           input logic [VW-1:0] l, input logic [IW-1:0] inc);
    cross_en[i] = en;
    cross_start_a[i*VW +: VW] = s;
    cross_len_a[i*VW +: VW]   = l;
    cross_inc_a[i*IW +: IW]   = inc;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Issue a step from IDLE, require done exactly 2N+1 cycles later, then move past DONE
  task automatic step_sweep(input string tag);
    int n;
    pulse_step();
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 5);
    @(negedge clk);
  endtask

  function automatic logic [31:0] acur(input int i);
    return 32'(auto_cur_a[i*VW +: VW]);
  endfunction

  function automatic logic [31:0] ccur(input int i);
    return 32'(cross_cur_a[i*VW +: VW]);
  endfunction

  // scoreboard of expected current values after a load (auto0, auto1, cross0, cross1)
  logic [VW-1:0] exp_q[$];

  initial begin
    int cnt;
    int n;
    reset = 1'b0; step = 1'b0; load = 1'b0; hold = 1'b0;
    auto_en = '0; cross_en = '0;
    auto_start_a = '0; auto_len_a = '0; auto_inc_a = '0;
    cross_start_a = '0; cross_len_a = '0; cross_inc_a = '0;
    set_auto(0, 1'b1, 20'd3, 20'd4, 12'd2);
    set_auto(1, 1'b0, 20'd10, 20'd0, 12'd0);
    set_cross(0, 1'b0, 20'd20, 20'd0, 12'd0);
    set_cross(1, 1'b0, 20'd7, 20'd0, 12'd0);
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_auto0", acur(0), 0);
    chk("rst_cross1", ccur(1), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_state", 32'(dbg_state), 0);
    reset = 1'b1;
    @(negedge clk);

    // load then three steps on auto0 (start 3, len 4, inc 2)
    pulse_load();
    exp_q = '{20'd3, 20'd10, 20'd20, 20'd7};
    chk("load_auto0", acur(0), 32'(exp_q[0]));
    chk("load_auto1", acur(1), 32'(exp_q[1]));
    chk("load_cross0", ccur(0), 32'(exp_q[2]));
    chk("load_cross1", ccur(1), 32'(exp_q[3]));
    chk("load_wrap", 32'(wrap), 0);
    step_sweep("a1");
    chk("a1_auto0", acur(0), 5);
    chk("a1_cross1_dis", ccur(1), 7);
    chk("a1_wrap", 32'(wrap), 0);
    chk("a1_state", 32'(dbg_state), 0);
    step_sweep("a2");
    chk("a2_auto0", acur(0), 3);
    chk("a2_wrap", 32'(wrap), 32'b0001);
    step_sweep("a3");
    chk("a3_auto0", acur(0), 5);
    chk("a3_wrap", 32'(wrap), 0);

    // limit above 20 bits on cross1: must advance, then wrap at 0x100000
    set_auto(0, 1'b0, 20'd3, 20'd4, 12'd2);
    set_cross(1, 1'b1, 20'hFFF00, 20'h00100, 12'h080);
    pulse_load();
    chk("b_load_cross1", ccur(1), 32'hFFF00);
    step_sweep("b1");
    chk("b1_cross1", ccur(1), 32'hFFF80);
    chk("b1_wrap", 32'(wrap), 0);
    step_sweep("b2");
    chk("b2_cross1", ccur(1), 32'hFFF00);
    chk("b2_wrap", 32'(wrap), 32'b1000);
    chk("b2_auto0_dis", acur(0), 3);

    // hold defers the sweep; a second step while pending is dropped
    hold = 1'b1;
    pulse_step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("c_busy_in_hold", cnt, 0);
    chk("c_pending", 32'(dbg_pending), 1);
    chk("c_drop0", 32'(drop_count), 0);
    pulse_step();
    chk("c_drop1", 32'(drop_count), 1);
    hold = 1'b0;
    @(negedge clk);
    chk("c_busy_rise", 32'(busy), 1);
    chk("c_pending_clr", 32'(dbg_pending), 0);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c_done_seen", 32'(done), 1);
    @(negedge clk);

    // step every cycle: back-to-back sweeps and drop counter saturation
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step = 1'b1;
      @(negedge clk);
      if (done) cnt++;
      if (i == 5) chk("d_back_to_back", 32'(busy), 1);
    end
    step = 1'b0;
    chk("d_done_count", cnt, 4);
    chk("d_drop_sat", 32'(drop_count), 3);
    n = 0;
    while (dbg_state != 2'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("d_idle", 32'(dbg_state), 0);

    // load together with step at sweep entry 2 aborts the sweep
    set_auto(0, 1'b1, 20'd3, 20'd4, 12'd2);
    set_auto(1, 1'b1, 20'd10, 20'd5, 12'd1);
    set_cross(0, 1'b1, 20'd20, 20'd8, 12'd3);
    set_cross(1, 1'b0, 20'd7, 20'd0, 12'd0);
    pulse_load();
    pulse_step();
    @(negedge clk);
    chk("e_mid_auto0", acur(0), 5);
    chk("e_mid_auto1_untouched", acur(1), 10);
    @(negedge clk);
    chk("e_mid_auto1", acur(1), 11);
    chk("e_mid_cross0_untouched", ccur(0), 20);
    load = 1'b1; step = 1'b1;
    @(negedge clk);
    load = 1'b0; step = 1'b0;
    chk("e_auto0", acur(0), 3);
    chk("e_auto1", acur(1), 10);
    chk("e_cross1", ccur(1), 7);
    chk("e_state", 32'(dbg_state), 0);
    chk("e_pending", 32'(dbg_pending), 0);
    chk("e_drop", 32'(drop_count), 3);
    chk("e_wrap", 32'(wrap), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("e_no_done", cnt, 0);

    // asynchronous reset mid-sweep
    pulse_step();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("f_auto0", acur(0), 0);
    chk("f_busy_done", {busy, done}, 0);
    chk("f_state", 32'(dbg_state), 0);
    chk("f_drop", 32'(drop_count), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    step_sweep("f");
    chk("f_auto0_after", acur(0), 2);
    chk("f_auto1_after", acur(1), 1);
    chk("f_cross0_after", ccur(0), 3);
    chk("f_cross1_after", ccur(1), 7);
    chk("f_wrap", 32'(wrap), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
